// File: rtl/svc_skidbuf_n_mem.sv
// DEPTH x DATA_WIDTH flop array with one synchronous write port and one async read port.
// Data storage carries no reset; validity is tracked by the owning FIFO.
module svc_skidbuf_n_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]      o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/svc_skidbuf_n.sv
// DEPTH-entry elastic buffer on a valid/ready stream with optional empty bypass
// or registered output stage; s_ready is derived from registered occupancy only.
module svc_skidbuf_n #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter bit OPT_OUTREG = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+2)-1:0]   count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DEPTH + 2);
  localparam int CAP = DEPTH + (OPT_OUTREG ? 1 : 0);
  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_mem_empty;
  logic                  w_mem_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_s_fire;
  logic                  w_m_fire;
  logic [DATA_WIDTH-1:0] w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_mem_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign s_ready  = (r_count < CAP_C);
  assign w_s_fire = s_valid && s_ready;
  assign w_m_fire = m_valid && m_ready;
  assign count    = r_count;

  svc_skidbuf_n_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (s_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

  generate
    if (OPT_OUTREG == 1'b0) begin : g_comb
      assign m_valid = !w_mem_empty || s_valid;
      assign m_data  = w_mem_empty ? s_data : w_head;
      // Empty with a ready consumer: the beat passes straight through, nothing stored.
      assign w_push  = w_s_fire && !(w_mem_empty && m_ready);
      assign w_pop   = w_m_fire && !w_mem_empty;
    end else begin : g_oreg
      logic                  r_oreg_valid;
      logic [DATA_WIDTH-1:0] r_oreg_data;
      logic                  w_load;

      assign w_load  = !r_oreg_valid || m_ready;
      assign w_pop   = w_load && !w_mem_empty;
      assign w_push  = w_s_fire && !(w_load && w_mem_empty);
      assign m_valid = r_oreg_valid;
      assign m_data  = r_oreg_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_oreg_valid <= 1'b0;
        end else if (w_load) begin
          r_oreg_valid <= !w_mem_empty || w_s_fire;
        end
      end

      // Memory head has priority; an incoming beat skips memory only when it is empty.
      always_ff @(posedge clk) begin
        if (!rst && w_load) begin
          if (!w_mem_empty) begin
            r_oreg_data <= w_head;
          end else if (w_s_fire) begin
            r_oreg_data <= s_data;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_s_fire && !w_m_fire) begin
        r_count <= r_count + 1'b1;
      end else if (w_m_fire && !w_s_fire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  a_count_cap: assert property (@(posedge clk) disable iff (rst) r_count <= CAP_C);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_mem_full));

endmodule

// File: tb/tb_svc_skidbuf_n.sv
// Directed bench for svc_skidbuf_n: one instance without and one with the output register.
module tb_svc_skidbuf_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      s_valid;
  logic [1:0]      m_ready;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_ready;
  logic [1:0]      m_valid;
  logic [1:0][7:0] m_data;
  logic [1:0][2:0] count;

  logic       s_ready0, s_ready1, m_valid0, m_valid1;
  logic [7:0] m_data0, m_data1;
  logic [2:0] count0, count1;

  assign s_ready = {s_ready1, s_ready0};
  assign m_valid = {m_valid1, m_valid0};
  assign m_data  = {m_data1, m_data0};
  assign count   = {count1, count0};

  int n_tests = 0;
  int n_fail  = 0;

  svc_skidbuf_n #(.DATA_WIDTH(8), .DEPTH(4), .OPT_OUTREG(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid[0]), .s_ready(s_ready0), .s_data(s_data[0]),
    .m_valid(m_valid0), .m_ready(m_ready[0]), .m_data(m_data0),
    .count(count0)
  );

  svc_skidbuf_n #(.DATA_WIDTH(8), .DEPTH(4), .OPT_OUTREG(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid[1]), .s_ready(s_ready1), .s_data(s_data[1]),
    .m_valid(m_valid1), .m_ready(m_ready[1]), .m_data(m_data1),
    .count(count1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_empty(input int d, input string tag);
    check_eq({tag, "_mvalid"}, 32'(m_valid[d]), 32'd0);
    check_eq({tag, "_count"},  32'(count[d]),   32'd0);
    check_eq({tag, "_sready"}, 32'(s_ready[d]), 32'd1);
  endtask

  // Continuous stream of n beats with m_ready toggling 1,0,1,0...
  task automatic stream(input int d, input int n);
    int         nin = 0;
    int         nout = 0;
    int         cyc = 0;
    logic       rdy = 1'b1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    int         cap = (d == 1) ? 5 : 4;
    while (nout < n && cyc < 400) begin
      @(negedge clk);
      s_valid[d] = (nin < n);
      s_data[d]  = 8'(nin);
      m_ready[d] = rdy;
      #1;
      if (prev_hold) begin
        check_eq("hold_valid", 32'(m_valid[d]), 32'd1);
        check_eq("hold_data",  32'(m_data[d]),  32'(prev_data));
      end
      check_eq("count_le_cap", 32'(int'(count[d]) <= cap), 32'd1);
      if (m_valid[d] && m_ready[d]) begin
        check_eq("stream_data", 32'(m_data[d]), 32'(nout));
        nout++;
      end
      prev_hold = m_valid[d] && !m_ready[d];
      prev_data = m_data[d];
      if (s_valid[d] && s_ready[d]) nin++;
      rdy = !rdy;
      cyc++;
    end
    check_eq("stream_done", 32'(nout), 32'(n));
    @(negedge clk);
    s_valid[d] = 1'b0;
    m_ready[d] = 1'b0;
  endtask

  // Three in, three out, ten rounds: pointers cross the 2*DEPTH wrap several times.
  task automatic wrap_test(input int d);
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        s_valid[d] = 1'b1;
        s_data[d]  = 8'(r * 3 + j);
        m_ready[d] = 1'b0;
        #1;
        check_eq("wrap_push_sready", 32'(s_ready[d]), 32'd1);
        check_eq("wrap_push_count",  32'(count[d]),   32'(j));
      end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        s_valid[d] = 1'b0;
        m_ready[d] = 1'b1;
        #1;
        if (j == 0) check_eq("wrap_full_count", 32'(count[d]), 32'd3);
        check_eq("wrap_pop_valid", 32'(m_valid[d]), 32'd1);
        check_eq("wrap_pop_data",  32'(m_data[d]),  32'(r * 3 + j));
      end
      @(negedge clk);
      m_ready[d] = 1'b0;
      #1;
      check_empty(d, "wrap_empty");
    end
  endtask

  initial begin
    int acc;
    rst     = 1'b1;
    s_valid = '0;
    m_ready = '0;
    s_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check_empty(d, "reset");

    // Zero-latency bypass when empty.
    @(negedge clk);
    s_valid[0] = 1'b1; s_data[0] = 8'hA5; m_ready[0] = 1'b1;
    #1;
    check_eq("byp_mvalid", 32'(m_valid[0]), 32'd1);
    check_eq("byp_mdata",  32'(m_data[0]),  32'hA5);
    check_eq("byp_count",  32'(count[0]),   32'd0);
    @(negedge clk);
    s_valid[0] = 1'b0;
    #1;
    check_eq("byp_after_mvalid", 32'(m_valid[0]), 32'd0);
    check_eq("byp_after_count",  32'(count[0]),   32'd0);

    // Fill to capacity, fifth beat held off, then drain with a refill.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid[0] = 1'b1; s_data[0] = 8'(8'h10 + i); m_ready[0] = 1'b0;
      #1;
      check_eq("fill_sready", 32'(s_ready[0]), 32'd1);
      check_eq("fill_count",  32'(count[0]),   32'(i));
    end
    @(negedge clk);
    s_data[0] = 8'h14;
    #1;
    check_eq("full_count",  32'(count[0]),   32'd4);
    check_eq("full_sready", 32'(s_ready[0]), 32'd0);
    check_eq("full_mdata",  32'(m_data[0]),  32'h10);
    @(negedge clk);
    m_ready[0] = 1'b1;
    #1;
    check_eq("drain0_mdata",  32'(m_data[0]),  32'h10);
    check_eq("drain0_sready", 32'(s_ready[0]), 32'd0);
    @(negedge clk);
    #1;
    check_eq("drain1_sready", 32'(s_ready[0]), 32'd1);
    check_eq("drain1_mvalid", 32'(m_valid[0]), 32'd1);
    check_eq("drain1_mdata",  32'(m_data[0]),  32'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_valid[0] = 1'b0;
      #1;
      check_eq("drain_mvalid", 32'(m_valid[0]), 32'd1);
      check_eq("drain_mdata",  32'(m_data[0]),  32'(8'h12 + k));
    end
    @(negedge clk);
    #1;
    check_empty(0, "drain_end");
    m_ready[0] = 1'b0;

    stream(0, 16);

    // Registered output: one cycle of latency.
    @(negedge clk);
    s_valid[1] = 1'b1; s_data[1] = 8'h55; m_ready[1] = 1'b1;
    #1;
    check_eq("oreg_push_mvalid", 32'(m_valid[1]), 32'd0);
    @(negedge clk);
    s_valid[1] = 1'b0;
    #1;
    check_eq("oreg_next_mvalid", 32'(m_valid[1]), 32'd1);
    check_eq("oreg_next_mdata",  32'(m_data[1]),  32'h55);
    @(negedge clk);
    #1;
    check_empty(1, "oreg_after");

    // Capacity with the output register is DEPTH+1.
    acc = 0;
    m_ready[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_valid[1] = 1'b1;
      s_data[1]  = 8'(8'h20 + acc);
      #1;
      if (s_ready[1]) acc++;
    end
    @(negedge clk);
    s_valid[1] = 1'b0;
    #1;
    check_eq("cap_accepted", 32'(acc),        32'd5);
    check_eq("cap_count",    32'(count[1]),   32'd5);
    check_eq("cap_sready",   32'(s_ready[1]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m_ready[1] = 1'b1;
      #1;
      check_eq("cap_drain_mvalid", 32'(m_valid[1]), 32'd1);
      check_eq("cap_drain_mdata",  32'(m_data[1]),  32'(8'h20 + k));
    end
    @(negedge clk);
    #1;
    check_empty(1, "cap_end");
    m_ready[1] = 1'b0;

    stream(1, 16);
    wrap_test(0);
    wrap_test(1);

    // Reset mid-stream discards held beats; inputs on the reset edge are ignored.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      s_valid = 2'b11;
      s_data[0] = 8'(8'h30 + j);
      s_data[1] = 8'(8'h30 + j);
      m_ready = 2'b00;
    end
    @(negedge clk);
    #1;
    check_eq("pre_rst_count0", 32'(count[0]), 32'd3);
    check_eq("pre_rst_count1", 32'(count[1]), 32'd3);
    rst = 1'b1;
    s_data[0] = 8'h99;
    s_data[1] = 8'h99;
    @(negedge clk);
    rst = 1'b0;
    s_valid = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) check_empty(d, "mid_rst");
    @(negedge clk);
    s_valid = 2'b11;
    s_data[0] = 8'h42;
    s_data[1] = 8'h42;
    @(negedge clk);
    s_valid = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("post_rst_mvalid", 32'(m_valid[d]), 32'd1);
      check_eq("post_rst_mdata",  32'(m_data[d]),  32'h42);
      check_eq("post_rst_count",  32'(count[d]),   32'd1);
    end
    @(negedge clk);
    m_ready = 2'b11;
    @(negedge clk);
    m_ready = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) check_empty(d, "post_rst_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
